// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Consumes a framed byte stream (16-bit little-endian word count, payload
// bytes packed little-endian into 32-bit words, XOR checksum) and issues
// one registered write per assembled word. The core is held in reset while
// a load is in progress; done/err report the outcome of the last load.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   start             one-cycle pulse, begins a load from IDLE/DONE/ERR
//   in_valid, in_data byte stream input
//   in_ready          byte accepted this cycle when in_valid is also high
//   wen, waddr, wdata instruction-memory write port (registered)
//   busy, cpu_hold    load in progress / core reset request (identical)
//   done, err         result of the last load (levels, mutually exclusive)
module imem_loader #(
    parameter int IMEM_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wen,
    output logic [IMEM_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int WIDX_W = IMEM_W - 2;
    // Largest legal word count; 17 bits so the compare never overflows.
    localparam logic [16:0] MAX_WORDS = 17'(2 ** WIDX_W);

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        byte_cnt;
    logic [WIDX_W-1:0] word_idx;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [7:0]        csum;
    logic [23:0]       lanes;

    logic        hs;
    logic [15:0] len_full;
    logic        len_ok;
    logic        last_word;
    logic        csum_ok;

    assign hs        = in_valid && in_ready;
    assign len_full  = {in_data, len_lo};
    assign len_ok    = (len_full != 16'd0) && ({1'b0, len_full} <= MAX_WORDS);
    assign last_word = (16'(word_idx) == (len - 16'd1));
    assign csum_ok   = (in_data == csum);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) state_nxt = LEN0;
            end
            LEN0: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (hs) state_nxt = LEN1;
            end
            LEN1: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (hs) state_nxt = len_ok ? DATA : ERR;
            end
            DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (hs && byte_cnt == 2'd3 && last_word) state_nxt = CHK;
            end
            CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (hs) state_nxt = csum_ok ? DONE : ERR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cpu_hold = busy;

    // Control and write-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            word_idx <= '0;
            wen      <= 1'b0;
            waddr    <= '0;
            wdata    <= 32'd0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wen <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        word_idx <= '0;
                        byte_cnt <= 2'd0;
                    end
                end
                LEN1: begin
                    if (hs && !len_ok) err <= 1'b1;
                end
                DATA: begin
                    if (hs) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wen   <= 1'b1;
                            waddr <= {word_idx, 2'b00};
                            wdata <= {in_data, lanes};
                            // Holding on the last word keeps word_idx from
                            // wrapping when the memory is filled completely.
                            if (!last_word) word_idx <= word_idx + 1'b1;
                        end
                    end
                end
                CHK: begin
                    if (hs) begin
                        if (csum_ok) done <= 1'b1;
                        else         err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload datapath: length capture, lane assembly and running checksum.
    always_ff @(posedge clk) begin
        case (state)
            IDLE, DONE, ERR: begin
                if (start) csum <= 8'd0;
            end
            LEN0: begin
                if (hs) len_lo <= in_data;
            end
            LEN1: begin
                if (hs) len <= len_full;
            end
            DATA: begin
                if (hs) begin
                    csum <= csum ^ in_data;
                    case (byte_cnt)
                        2'd0:    lanes[7:0]   <= in_data;
                        2'd1:    lanes[15:8]  <= in_data;
                        2'd2:    lanes[23:16] <= in_data;
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (IMEM_W = 13).
module tb_imem_loader;

    localparam int IMEM_W = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wen;
    logic [IMEM_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    // Write log filled from the write port, read back by the directed steps.
    int          wr_cnt = 0;
    logic [31:0] log_a [0:8191];
    logic [31:0] log_d [0:8191];

    imem_loader #(.IMEM_W(IMEM_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wen      (wen),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wen) begin
            if (wr_cnt < 8192) begin
                log_a[wr_cnt] <= 32'(waddr);
                log_d[wr_cnt] <= wdata;
            end
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents one byte and returns 1 time unit after the edge that took it.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: observed no in_ready required in_ready=1 for byte %h", b);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_wen"},      32'(wen),      32'd0);
        check({tag, "_waddr"},    32'(waddr),    32'd0);
        check({tag, "_wdata"},    wdata,         32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
    endtask

    int base;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // in_valid in IDLE: nothing accepted, nothing written.
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) tick();
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_no_write", 32'(wr_cnt), 32'd0);
        in_valid = 1'b0;

        // 1-word load, no stalls.
        base = wr_cnt;
        pulse_start();
        check("w1_busy_after_start", 32'(busy), 32'd1);
        check("w1_cpu_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        check("w1_wen_latency", 32'(wen), 32'd1);
        check("w1_wdata_now", wdata, 32'h00A00513);
        send_byte(8'hB6);
        check("w1_wen_single", 32'(wen), 32'd0);
        check("w1_done", 32'(done), 32'd1);
        check("w1_err", 32'(err), 32'd0);
        check("w1_busy", 32'(busy), 32'd0);
        check("w1_wr_count", 32'(wr_cnt - base), 32'd1);
        check("w1_waddr", log_a[base], 32'h000);
        check("w1_wdata", log_d[base], 32'h00A00513);

        // 3-word load with in_valid toggled every other cycle; CHK = 0x40.
        base = wr_cnt;
        pulse_start();
        check("w3_done_cleared", 32'(done), 32'd0);
        send_byte(8'h03); tick(); send_byte(8'h00); tick();
        send_byte(8'h44); tick(); send_byte(8'h33); tick();
        send_byte(8'h22); tick(); send_byte(8'h11); tick();
        send_byte(8'hDD); tick(); send_byte(8'hCC); tick();
        send_byte(8'hBB); tick(); send_byte(8'hAA); tick();
        send_byte(8'h04); tick(); send_byte(8'h03); tick();
        send_byte(8'h02); tick(); send_byte(8'h01); tick();
        send_byte(8'h40);
        tick();
        check("w3_done", 32'(done), 32'd1);
        check("w3_err", 32'(err), 32'd0);
        check("w3_wr_count", 32'(wr_cnt - base), 32'd3);
        check("w3_addr0", log_a[base],     32'h000);
        check("w3_data0", log_d[base],     32'h11223344);
        check("w3_addr1", log_a[base + 1], 32'h004);
        check("w3_data1", log_d[base + 1], 32'hAABBCCDD);
        check("w3_addr2", log_a[base + 2], 32'h008);
        check("w3_data2", log_d[base + 2], 32'h01020304);

        // Bad checksum: word still written, err raised.
        base = wr_cnt;
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        send_byte(8'h00);
        check("bad_err", 32'(err), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_busy", 32'(busy), 32'd0);
        check("bad_wr_count", 32'(wr_cnt - base), 32'd1);
        check("bad_wdata", log_d[base], 32'h00A00513);

        // Recovery after error.
        pulse_start();
        check("rec_err_cleared", 32'(err), 32'd0);
        check("rec_busy", 32'(busy), 32'd1);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        send_byte(8'hB6);
        check("rec_done", 32'(done), 32'd1);
        check("rec_err", 32'(err), 32'd0);

        // Length 0 is an error; nothing accepted afterwards.
        base = wr_cnt;
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        check("len0_err", 32'(err), 32'd1);
        check("len0_done", 32'(done), 32'd0);
        check("len0_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h12;
        repeat (2) tick();
        in_valid = 1'b0;
        check("len0_in_ready_later", 32'(in_ready), 32'd0);
        check("len0_no_write", 32'(wr_cnt - base), 32'd0);

        // Length 0x0801 exceeds 2048 words.
        pulse_start();
        send_byte(8'h01); send_byte(8'h08);
        check("len801_err", 32'(err), 32'd1);
        check("len801_busy", 32'(busy), 32'd0);

        // Length 0x0800 fills memory; byte i of payload is i[7:0], XOR = 0.
        base = wr_cnt;
        pulse_start();
        send_byte(8'h00); send_byte(8'h08);
        for (int i = 0; i < 8192; i++) send_byte(8'(i));
        send_byte(8'h00);
        tick();
        check("full_done", 32'(done), 32'd1);
        check("full_err", 32'(err), 32'd0);
        check("full_wr_count", 32'(wr_cnt - base), 32'd2048);
        check("full_first_data", log_d[base], 32'h03020100);
        check("full_last_addr", log_a[base + 2047], 32'h1FFC);
        check("full_last_data", log_d[base + 2047], 32'hFFFEFDFC);

        // rst after 6 payload bytes of a 2-word frame.
        base = wr_cnt;
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        rst = 1'b1;
        tick();
        check_idle_outputs("midrst");
        rst = 1'b0;
        tick();
        check("midrst_wr_count", 32'(wr_cnt - base), 32'd1);
        check("midrst_word0", log_d[base], 32'h44332211);

        // Full load after reset, with a start pulse during DATA.
        base = wr_cnt;
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05);
        start = 1'b1;
        send_byte(8'hA0);
        start = 1'b0;
        check("dstart_busy", 32'(busy), 32'd1);
        send_byte(8'h00);
        send_byte(8'hB6);
        tick();
        check("dstart_done", 32'(done), 32'd1);
        check("dstart_err", 32'(err), 32'd0);
        check("dstart_wr_count", 32'(wr_cnt - base), 32'd1);
        check("dstart_waddr", log_a[base], 32'h000);
        check("dstart_wdata", log_d[base], 32'h00A00513);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
